data_memory_be: RTL
===================

// Module: data_memory_be
// PURPOSE
//  Parametrised byte-addressable MIPS data memory; successor to the single-cycle word RAM.
//  Adds byte/half/word access with sign/zero extension and a registered (1-cycle) read.
//  Adds misalignment detection and a sequential clear engine instead of a one-cycle wipe.
//  Sits in the MEM stage between the ALU result/rt forwarding path and the WB mux.
// PARAMETERS
//  ADDR_W          8    word-address bits; DEPTH = 2**ADDR_W words of 32 bits
//  CLEAR_ON_RESET  1    1: run clear engine after reset release; 0: go straight to IDLE
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low reset
//  MemWrite     in   1   store request (sampled at posedge)
//  MemRead      in   1   load request (sampled at posedge)
//  MemSize      in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  MemSigned    in   1   1: sign-extend byte/half loads; 0: zero-extend
//  ClearReq     in   1   1-cycle pulse: restart clear engine (ignored while busy)
//  ALUresult    in   32  byte address; word index = ALUresult[ADDR_W+1:2], upper bits ignored (wrap)
//  WriteData    in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  data_result  out  32  load data, valid when data_valid=1, else holds last value
//  data_valid   out  1   pulses 1 cycle after an accepted load
//  busy         out  1   1 while clear engine runs; all requests ignored
//  misaligned   out  1   registered; pulses 1 cycle after a misaligned request
//  parity_err   out  1   see CONFIGURATION; 0 when feature compiled out
// BEHAVIOUR
//  Reset (reset=0): data_result=0, data_valid=0, misaligned=0, parity_err=0, clear counter=0.
//   State=CLEAR if CLEAR_ON_RESET else IDLE. RAM contents are not touched asynchronously.
//  FSM states:
//   CLEAR: writes word[cnt]=0 and cnt++ each cycle; busy=1. After cnt=DEPTH-1, go to IDLE (DEPTH cycles).
//   IDLE: busy=0; accepts requests; ClearReq=1 -> CLEAR with cnt=0 on next edge.
//  Reset asserted mid-clear: counter back to 0. Clear restarts from word 0 after release.
//  Requests (MemRead/MemWrite) during CLEAR are dropped: no write, no data_valid, no misaligned.
//  Alignment (off = ALUresult[1:0]):
//   byte: any off. half: off[0] must be 0. word: off must be 00.
//   Misaligned -> write suppressed, load suppressed (no data_valid), misaligned=1 next cycle.
//  Store lanes: byte -> lane off gets WriteData[7:0]; half -> lanes {off[1],1},{off[1],0} get WriteData[15:0];
//   word -> all 4 lanes. Other lanes of the word are unchanged.
//  Load: word read registered at posedge. Lane extracted by off, extended per MemSigned, into data_result.
//   data_valid=1 for exactly one cycle. Latency = 1 cycle; back-to-back loads give one result per cycle.
//  MemRead and MemWrite same cycle, same word: write happens; load returns OLD contents (read-before-write).
//  Write then read next cycle, same address: read returns new data (no bypass needed; RAM already updated).
//  ClearReq concurrent with an access in IDLE: access completes this edge, CLEAR starts next cycle.
// CONFIGURATION
//  DMEM_PARITY_EN defined: one even-parity bit per byte lane, stored on every write (clear writes parity 0).
//   On an accepted load, any lane parity mismatch in the read word sets parity_err=1 for one cycle,
//   aligned with data_valid. Data is still returned.
//  DMEM_PARITY_EN undefined: no parity storage; parity_err tied 0.
// TESTING
//  reset low 3 cycles, release with CLEAR_ON_RESET=1 -> busy=1 for 256 cycles; then read 0x0FC -> 0x00000000.
//  sw 0x11223344 @0x010; lb signed @0x013 -> 0x00000011; lb @0x010 -> 0x00000044; lhu @0x012 -> 0x00001122.
//  sb 0x000000F0 @0x021 over word 0 -> word 0x0000F000; lb signed @0x021 -> 0xFFFFF000? no: 0xFFFFFFF0.
//  sh @0x023 or sw @0x022 -> misaligned=1 next cycle, memory unchanged, data_valid=0.
//  same-cycle sw 0xAAAA5555 + lw @0x040 holding 0x12345678 -> data_result 0x12345678; next lw -> 0xAAAA5555.
//  ClearReq mid-run, then reset low at cnt=100 -> after release busy lasts full 256 cycles; loads ignored meanwhile.

Source files
------------

// File: rtl/data_memory_be.sv
// Byte-addressable MIPS data memory: byte/half/word loads and stores, registered read,
// misalignment flag, sequential clear engine. Optional lane parity via DMEM_PARITY_EN.
module data_memory_be #(
    parameter int ADDR_W         = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic        ClearReq,
    input  logic [31:0] ALUresult,
    input  logic [31:0] WriteData,
    output logic [31:0] data_result,
    output logic        data_valid,
    output logic        busy,
    output logic        misaligned,
    output logic        parity_err
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  cnt;
    logic [31:0]        mem [DEPTH];

    logic [ADDR_W-1:0]  idx;
    logic [1:0]         off;
    logic               idle, aligned, rd_ok, wr_ok, perr;
    logic [3:0]         be;
    logic [31:0]        wlanes, rword, ldata;
    logic [7:0]         rbyte;
    logic [15:0]        rhalf;
    logic               unused_addr;

    assign idx         = ALUresult[ADDR_W+1:2];
    assign off         = ALUresult[1:0];
    assign unused_addr = ^ALUresult[31:ADDR_W+2];
    assign idle        = (state == S_IDLE);
    assign busy        = (state == S_CLEAR);
    assign rd_ok       = idle & MemRead & aligned;
    assign wr_ok       = idle & MemWrite & aligned;

    // Store data is replicated across lanes so the byte enables alone pick the target lane.
    always_comb begin
        aligned = 1'b1;
        be      = '1;
        wlanes  = WriteData;
        case (MemSize)
            2'b00: begin
                be     = 4'b0001 << off;
                wlanes = {4{WriteData[7:0]}};
            end
            2'b01: begin
                aligned = ~off[0];
                be      = off[1] ? 4'b1100 : 4'b0011;
                wlanes  = {2{WriteData[15:0]}};
            end
            default: aligned = (off == 2'b00);
        endcase
    end

    always_comb begin
        rword = mem[idx];
        rbyte = rword[{off, 3'b000} +: 8];
        rhalf = off[1] ? rword[31:16] : rword[15:0];
        case (MemSize)
            2'b00:   ldata = {{24{MemSigned & rbyte[7]}}, rbyte};
            2'b01:   ldata = {{16{MemSigned & rhalf[15]}}, rhalf};
            default: ldata = rword;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

`ifdef DMEM_PARITY_EN
    logic [3:0] par [DEPTH];

    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            par[cnt] <= '0;
        end else if (wr_ok) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) par[idx][i] <= ^wlanes[8*i +: 8];
            end
        end
    end

    always_comb begin
        perr = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if ((^rword[8*i +: 8]) != par[idx][i]) perr = 1'b1;
        end
    end
`else
    assign perr = 1'b0;
`endif

    // Load data is taken from the pre-edge RAM value, giving read-before-write on collisions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            cnt         <= '0;
            data_result <= '0;
            data_valid  <= 1'b0;
            misaligned  <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            data_valid <= rd_ok;
            misaligned <= idle & (MemRead | MemWrite) & ~aligned;
            parity_err <= rd_ok & perr;
            if (rd_ok) data_result <= ldata;
            case (state)
                S_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) state <= S_IDLE;
                end
                S_IDLE: begin
                    if (ClearReq) begin
                        state <= S_CLEAR;
                        cnt   <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
